counter_en_gen: RTL and testbench
=================================

Name: counter_en_gen

Overview:
- Periodic single-cycle enable (tick) generator used for frame timing and speed control of sprite motion.
- Contains two independent period counters:
  - one with a compile-time period (frame tick);
  - one whose period is supplied at run time on an input bus (jump/gravity step rate).
- Consumers gate their state updates with these pulses instead of using derived clocks.

Parameters:
- SIZE, 60, fixed period in clock cycles of fixed_en; legal range 1..2^WIDTH-1.
- WIDTH, 32, width of the size input and of both internal counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- size  input  WIDTH  run-time period, in cycles, of var_en; sampled every cycle, unsigned.
- fixed_en  output  1  one-cycle pulse every SIZE cycles.
- var_en  output  1  one-cycle pulse every size cycles.

Behaviour:
- Each channel has a registered counter cnt[WIDTH-1:0] and a combinational output decode; there is no output register.
- Reset:
  - rst asserted forces both counters to 0 immediately, regardless of clk.
  - fixed_en = 0 while in reset (SIZE>1).
  - var_en = 0 while in reset (size>1).
  - Reset mid-count abandons the current period; counting restarts from 0 on the first edge after release.
- Fixed channel:
  - Let P = SIZE.
  - fixed_en = (cnt == P-1).
  - On each edge: cnt <= (cnt == P-1) ? 0 : cnt+1.
  - The first pulse occurs in the cycle after the (P-1)th rising edge following reset release. Pulses then repeat exactly every P cycles, each 1 cycle wide.
  - SIZE = 1: fixed_en is constantly 1 after reset, and 1 during reset.
- Variable channel:
  - Let P = size as currently presented (combinational use, no capture).
  - var_en = (P != 0) && (cnt >= P-1).
  - On each edge, when P != 0: cnt <= (cnt >= P-1) ? 0 : cnt+1.
  - Shrinking size below the current count: the `>=` compare makes var_en pulse immediately and the counter wraps to 0. There is no long wrap-around through 2^WIDTH.
  - Growing size mid-count: the counter continues and the pulse fires when cnt reaches the new P-1.
  - size = 0: channel disabled; cnt held at 0 and var_en = 0.
  - size = 1: var_en is high every cycle.
  - A change of size takes effect in the same cycle (combinational compare).
- The channels are fully independent; simultaneous pulses are allowed.
- No arithmetic overflow occurs: cnt never exceeds max(P-1, previous cnt), and it wraps only to 0.

Decomposition:
- Shared package: the WIDTH default and the default frame period 60 as named constants (FRAME_PERIOD), plus the jump/gravity step-period constants 10, 12, 15, 20, 30, 60 used by consumers.
- One sub-module, period_counter (inputs clk, rst, period[WIDTH-1:0]; output tick), implements the variable-channel rules.
- counter_en_gen instantiates period_counter twice:
  - once with period tied to SIZE (fixed_en);
  - once driven by size (var_en).

Test Plan:
- Reset and fixed period: 10 ns clock, SIZE=60, rst high for 10 ns.
  - During reset: fixed_en = 0.
  - After release: first fixed_en pulse after 59 edges; subsequent pulses every 600 ns, 1 cycle wide.
  - Over 100 us: count exactly 166 pulses ±1.
- Variable period sweep: size stepped 10, 12, 15, 20, 30, 60, each held for 5 periods.
  - Spacing between var_en pulses equals the current size; widths are 1 cycle.
- Size shrink mid-count: size=60, wait until cnt=40, switch size to 10.
  - var_en pulses in the same cycle; the next pulse arrives 10 cycles later.
- Size = 0 and size = 1:
  - size=0 for 1000 cycles: var_en never asserts and cnt stays 0.
  - size=1: var_en high every cycle.
  - Returning size to 10: first pulse after 9 edges.
- Asynchronous reset mid-operation: assert rst between clock edges with cnt=30 (SIZE=60, size=20).
  - Both outputs drop immediately.
  - After release: fixed_en first pulses after 59 edges and var_en after 19 edges.

Source files
------------

// File: rtl/counter_en_gen_pkg.sv
// Shared timing constants for the enable generator and the sprite-motion consumers
// that select jump/gravity step rates.
package counter_en_gen_pkg;

  localparam int unsigned DEFAULT_WIDTH = 32;
  localparam int unsigned FRAME_PERIOD  = 60;

  localparam int unsigned STEP_PERIOD_10 = 10;
  localparam int unsigned STEP_PERIOD_12 = 12;
  localparam int unsigned STEP_PERIOD_15 = 15;
  localparam int unsigned STEP_PERIOD_20 = 20;
  localparam int unsigned STEP_PERIOD_30 = 30;
  localparam int unsigned STEP_PERIOD_60 = 60;

  typedef enum logic [2:0] {
    STEP_10,
    STEP_12,
    STEP_15,
    STEP_20,
    STEP_30,
    STEP_60
  } step_rate_e;

  function automatic int unsigned step_period(input step_rate_e rate);
    int unsigned p;
    case (rate)
      STEP_10: p = STEP_PERIOD_10;
      STEP_12: p = STEP_PERIOD_12;
      STEP_15: p = STEP_PERIOD_15;
      STEP_20: p = STEP_PERIOD_20;
      STEP_30: p = STEP_PERIOD_30;
      default: p = STEP_PERIOD_60;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/counter_en_gen_period_counter.sv
// Period counter emitting a one-cycle tick every `period` cycles; period 0 disables
// the channel and the period may change on any cycle.
module period_counter
  import counter_en_gen_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] period,
  output logic             tick
);

  logic [WIDTH-1:0] cnt;
  logic             active;

  assign active = (period != '0);
  // >= rather than == so a period shrunk below the current count wraps at once
  assign tick   = active && (cnt >= (period - WIDTH'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!active) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/counter_en_gen.sv
// Frame-tick and run-time-rate tick generator; consumers use the pulses as clock
// enables instead of derived clocks.
module counter_en_gen
  import counter_en_gen_pkg::*;
#(
  parameter int unsigned SIZE  = FRAME_PERIOD,
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] size,
  output logic             fixed_en,
  output logic             var_en
);

  localparam logic [WIDTH-1:0] FIXED_PERIOD = WIDTH'(SIZE);

  period_counter #(
    .WIDTH (WIDTH)
  ) u_fixed (
    .clk    (clk),
    .rst    (rst),
    .period (FIXED_PERIOD),
    .tick   (fixed_en)
  );

  period_counter #(
    .WIDTH (WIDTH)
  ) u_var (
    .clk    (clk),
    .rst    (rst),
    .period (size),
    .tick   (var_en)
  );

endmodule

// File: tb/tb_counter_en_gen.sv
// Directed self-checking bench for counter_en_gen (SIZE=60, WIDTH=32).
module tb_counter_en_gen;

  logic        clk;
  logic        rst;
  logic [31:0] size;
  logic        fixed_en;
  logic        var_en;

  int n_checks = 0;
  int n_fail   = 0;

  counter_en_gen #(
    .SIZE  (60),
    .WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .size     (size),
    .fixed_en (fixed_en),
    .var_en   (var_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  // Edges until the selected output is next seen high; maxc+1 on timeout
  task automatic wait_pulse(input bit use_var, input int maxc, output int n);
    n = 0;
    do begin
      step_edge();
      n++;
    end while (((use_var ? var_en : fixed_en) !== 1'b1) && (n <= maxc));
  endtask

  task automatic measure_both(input int maxc, output int fe, output int ve);
    fe = 0;
    ve = 0;
    for (int k = 1; k <= maxc; k++) begin
      step_edge();
      if (fixed_en === 1'b1 && fe == 0) fe = k;
      if (var_en === 1'b1 && ve == 0) ve = k;
      if (fe != 0 && ve != 0) break;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fe, ve, pulses, hi, max_cnt;
    int unsigned sweep [6];
    sweep = '{10, 12, 15, 20, 30, 60};

    // Reset and fixed period
    rst  = 1'b1;
    size = 32'd20;
    #1;
    check_eq("rst_fixed_en", {31'd0, fixed_en}, 32'd0);
    check_eq("rst_var_en", {31'd0, var_en}, 32'd0);
    step_edge();
    check_eq("rst_edge_fixed_cnt", dut.u_fixed.cnt, 32'd0);
    check_eq("rst_edge_fixed_en", {31'd0, fixed_en}, 32'd0);
    #4;
    rst = 1'b0;

    measure_both(200, fe, ve);
    check_eq("first_fixed_edges", fe, 32'd59);
    check_eq("first_var_edges", ve, 32'd19);
    wait_pulse(1'b0, 200, n);
    check_eq("fixed_spacing_1", n, 32'd60);
    wait_pulse(1'b0, 200, n);
    check_eq("fixed_spacing_2", n, 32'd60);

    pulses = 0;
    repeat (10000) begin
      step_edge();
      if (fixed_en === 1'b1) pulses++;
    end
    check_eq("fixed_100us_count", {31'd0, (pulses >= 165 && pulses <= 167)}, 32'd1);

    // Variable period sweep
    foreach (sweep[i]) begin
      size = sweep[i];
      wait_pulse(1'b1, 200, n);
      for (int j = 0; j < 5; j++) begin
        wait_pulse(1'b1, 200, n);
        check_eq($sformatf("var_spacing_p%0d_%0d", sweep[i], j), n, sweep[i]);
      end
    end

    // Shrink mid-count: size is 60 and var_en was just seen high
    repeat (41) step_edge();
    check_eq("shrink_pre_var_en", {31'd0, var_en}, 32'd0);
    check_eq("shrink_pre_cnt", dut.u_var.cnt, 32'd40);
    size = 32'd10;
    #1;
    check_eq("shrink_immediate", {31'd0, var_en}, 32'd1);
    wait_pulse(1'b1, 200, n);
    check_eq("shrink_next_spacing", n, 32'd10);

    // size = 0 and size = 1
    size = 32'd1;
    step_edge();
    size = 32'd0;
    #1;
    hi = 0;
    max_cnt = 0;
    repeat (1000) begin
      if (var_en === 1'b1) hi++;
      step_edge();
      if (int'(dut.u_var.cnt) > max_cnt) max_cnt = int'(dut.u_var.cnt);
    end
    check_eq("size0_no_pulse", hi, 32'd0);
    check_eq("size0_cnt_zero", max_cnt, 32'd0);
    size = 32'd1;
    #1;
    hi = 0;
    repeat (20) begin
      if (var_en === 1'b1) hi++;
      step_edge();
    end
    check_eq("size1_every_cycle", hi, 32'd20);
    size = 32'd10;
    #1;
    check_eq("size10_resume_low", {31'd0, var_en}, 32'd0);
    wait_pulse(1'b1, 200, n);
    check_eq("size10_first_edges", n, 32'd9);

    // Asynchronous reset mid-operation
    size = 32'd20;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (30) step_edge();
    check_eq("pre_async_fixed_cnt", dut.u_fixed.cnt, 32'd30);
    check_eq("pre_async_var_cnt", dut.u_var.cnt, 32'd10);
    #1;
    rst = 1'b1;
    #1;
    check_eq("async_fixed_cnt", dut.u_fixed.cnt, 32'd0);
    check_eq("async_var_cnt", dut.u_var.cnt, 32'd0);
    check_eq("async_fixed_en", {31'd0, fixed_en}, 32'd0);
    check_eq("async_var_en", {31'd0, var_en}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    measure_both(200, fe, ve);
    check_eq("post_async_fixed_edges", fe, 32'd59);
    check_eq("post_async_var_edges", ve, 32'd19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
